// File: rtl/jtvigil_pcmx.sv
// jtvigil_pcmx: multi-channel 8-bit PCM sample player.
// Each channel walks a ROM byte range (start..end) at the sample rate given
// by cen, or on CPU step edges in manual mode. A single fetch engine serves
// channels in fixed priority (lowest index first) over a shared ROM port.
module jtvigil_pcmx #(
  parameter int CH = 2,
  parameter int AW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [$clog2(CH)+2:0]   addr,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic                    rom_cs,
  output logic [AW-1:0]           rom_addr,
  input  logic [7:0]              rom_data,
  input  logic                    rom_ok,
  output logic [CH*8-1:0]         snd,
  output logic                    irq
);

  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} st_t;

  st_t           st_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] rom_addr_q;
  logic          rom_cs_q;
  logic          disc_q;

  logic [AW-1:0] start_q [CH];
  logic [AW-1:0] start_d [CH];
  logic [AW-1:0] end_q   [CH];
  logic [AW-1:0] end_d   [CH];
  logic [AW-1:0] cur_q   [CH];
  logic [AW-1:0] cur_d   [CH];
  logic [7:0]    snd_q   [CH];
  logic [7:0]    snd_d   [CH];
  logic [CH-1:0] busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [CH-1:0] loop_q, loop_d, man_q, man_d, step_q, step_d, stpp_q, stpp_d;
  logic [CH-1:0] dset, wsel;

  logic [2:0]    wreg;
  int            wch;
  logic          fin;
  logic          any_pend;
  logic [SW-1:0] nxt_ch;
  logic          kill;

  assign wreg = addr[2:0];
  assign fin  = (st_q == WAIT) && rom_ok;

  // Decode the CPU channel select and pick the next channel to fetch.
  always_comb begin
    wch      = int'(addr >> 3);
    any_pend = |(pend_q & busy_q);
    nxt_ch   = '0;
    wsel     = '0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (pend_q[c] && busy_q[c]) nxt_ch = SW'(c);
      wsel[c] = wr && (wch == c);
    end
    // A key-off aimed at the channel the engine is (about to be) serving
    // marks the in-flight sample as stale so it is never written to snd.
    kill = wr && (wreg == 3'd6) && !din[0] &&
           (wch == int'((st_q == IDLE) ? nxt_ch : sel_q));
  end

  // Per-channel next state: fetch completion, then CPU writes, then ticks.
  always_comb begin
    dset   = '0;
    busy_d = busy_q;
    pend_d = pend_q;
    loop_d = loop_q;
    man_d  = man_q;
    step_d = step_q;
    stpp_d = step_q;
    for (int c = 0; c < CH; c++) begin
      start_d[c] = start_q[c];
      end_d[c]   = end_q[c];
      cur_d[c]   = cur_q[c];
      snd_d[c]   = snd_q[c];

      if (fin && (int'(sel_q) == c) && !disc_q) begin
        snd_d[c]  = rom_data;
        pend_d[c] = 1'b0;
        if (cur_q[c] == end_q[c]) begin
          if (loop_q[c]) begin
            cur_d[c] = start_q[c];
          end else begin
            busy_d[c] = 1'b0;
            dset[c]   = 1'b1;
          end
        end else begin
          cur_d[c] = cur_q[c] + AW'(1);
        end
      end

      if (wsel[c]) begin
        case (wreg)
          3'd0, 3'd1, 3'd2: begin
            for (int b = 0; b < AW; b++)
              if (b / 8 == int'(wreg)) start_d[c][b] = din[b % 8];
          end
          3'd3, 3'd4, 3'd5: begin
            for (int b = 0; b < AW; b++)
              if (b / 8 == int'(wreg) - 3) end_d[c][b] = din[b % 8];
          end
          3'd6: begin
            loop_d[c] = din[1];
            man_d[c]  = din[2];
            if (din[0]) begin
              busy_d[c] = 1'b1;
              cur_d[c]  = start_q[c];
            end else begin
              busy_d[c] = 1'b0;
              pend_d[c] = 1'b0;
              snd_d[c]  = 8'h00;
            end
          end
          default: step_d[c] = din[0];
        endcase
      end

      if (busy_d[c] && ((!man_q[c] && cen) || (man_q[c] && step_q[c] && !stpp_q[c])))
        pend_d[c] = 1'b1;
    end
    done_d = (done_q & ~{CH{rd}}) | dset;
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        start_q[c] <= '0;
        end_q[c]   <= '0;
        cur_q[c]   <= '0;
        snd_q[c]   <= '0;
      end
      busy_q <= '0;
      done_q <= '0;
      pend_q <= '0;
      loop_q <= '0;
      man_q  <= '0;
      step_q <= '0;
      stpp_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        start_q[c] <= start_d[c];
        end_q[c]   <= end_d[c];
        cur_q[c]   <= cur_d[c];
        snd_q[c]   <= snd_d[c];
      end
      busy_q <= busy_d;
      done_q <= done_d;
      pend_q <= pend_d;
      loop_q <= loop_d;
      man_q  <= man_d;
      step_q <= step_d;
      stpp_q <= stpp_d;
    end
  end

  // Fetch engine: present the address, request, then wait for rom_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      sel_q      <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      disc_q     <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (any_pend) begin
            sel_q      <= nxt_ch;
            rom_addr_q <= cur_q[nxt_ch];
            disc_q     <= kill;
            st_q       <= ADDR;
          end
        end
        ADDR: begin
          rom_cs_q <= 1'b1;
          disc_q   <= disc_q | kill;
          st_q     <= WAIT;
        end
        WAIT: begin
          disc_q <= disc_q | kill;
          if (rom_ok) begin
            rom_cs_q <= 1'b0;
            st_q     <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Status port: busy in the low nibble, done flags in the high nibble.
  always_comb begin
    dout = 8'h00;
    if (rd) begin
      for (int c = 0; c < CH; c++) begin
        dout[c]     = busy_q[c];
        dout[c + 4] = done_q[c];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_snd
    assign snd[g*8 +: 8] = snd_q[g];
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign irq      = |done_q;

endmodule

// File: tb/tb_jtvigil_pcmx.sv
// Bench for jtvigil_pcmx (CH=2, AW=16): a table of register/status vectors,
// a ROM responder with two-clock latency, and a fetch-address scoreboard.
module tb_jtvigil_pcmx;
  localparam int CH = 2;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [3:0]    addr = '0;
  logic [7:0]    din = '0;
  logic [7:0]    dout;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = '0;
  logic          rom_ok = 1'b0;
  logic [15:0]   snd;
  logic          irq;

  always #5 clk = ~clk;

  jtvigil_pcmx #(.CH(CH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .rd(rd), .addr(addr),
    .din(din), .dout(dout), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .snd(snd), .irq(irq)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          fetches = 0;
  int          wcnt = 0;
  logic        cs_prev = 1'b0;
  logic [15:0] expq[$];

  function automatic logic [7:0] romv(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ROM responder: data valid two clocks after the request rises.
  always @(negedge clk) begin
    if (rom_cs) begin
      wcnt++;
      rom_ok   = (wcnt >= 2);
      rom_data = romv(rom_addr);
    end else begin
      wcnt     = 0;
      rom_ok   = 1'b0;
      rom_data = 8'h00;
    end
  end

  // Scoreboard: every new request must match the next expected address.
  always @(negedge clk) begin
    if (rom_cs && !cs_prev) begin
      fetches++;
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_fetch: rom_addr=%0h, expected no request", rom_addr);
      end else begin
        check("fetch_addr", 32'(rom_addr), 32'(expq.pop_front()));
      end
    end
    cs_prev = rom_cs;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wreg(input logic [3:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    idle(11);
  endtask

  task automatic prog(input logic c, input logic [23:0] s, input logic [23:0] e);
    for (int r = 0; r < 3; r++) wreg({c, 3'(r)}, s[8*r +: 8]);
    for (int r = 0; r < 3; r++) wreg({c, 3'(r + 3)}, e[8*r +: 8]);
  endtask

  task automatic wait_cs(input logic lvl, input string nm);
    int n = 0;
    while (rom_cs !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(rom_cs), 32'(lvl));
  endtask

  task automatic status(output logic [7:0] v);
    rd = 1'b1;
    #1 v = dout;
    @(negedge clk);
    rd = 1'b0;
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t        tbl[10];
  logic [7:0]  v;
  int          f0;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 4'h6, 8'h01, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h01};
    tbl[3] = '{1'b1, 1'b0, 4'hE, 8'h01, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h03};
    tbl[5] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 4'h6, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h02};
    tbl[8] = '{1'b1, 1'b0, 4'hE, 8'h00, 8'h00};
    tbl[9] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h00};

    idle(3);
    check("rst_rom_cs", 32'(rom_cs), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_snd", 32'(snd), 0);
    check("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 10; i++) begin
      wr = tbl[i].w; rd = tbl[i].r; addr = tbl[i].a; din = tbl[i].d;
      #1 check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].e));
      @(negedge clk);
    end
    wr = 1'b0; rd = 1'b0;

    // One-shot sample of three bytes, then a tick with nothing to do.
    prog(1'b0, 24'h000100, 24'h000102);
    expq.push_back(16'h0100); expq.push_back(16'h0101); expq.push_back(16'h0102);
    wreg(4'h6, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("A_snd%0d", i), 32'(snd[7:0]), 32'(romv(16'(16'h0100 + i))));
    end
    tick();
    check("A_snd_hold", 32'(snd[7:0]), 32'(romv(16'h0102)));
    check("A_irq", 32'(irq), 1);
    check("A_queue", 32'(expq.size()), 0);
    status(v);
    check("A_status", 32'(v), 32'h10);
    check("A_irq_clear", 32'(irq), 0);

    // Looping playback.
    expq.push_back(16'h0100); expq.push_back(16'h0101); expq.push_back(16'h0102);
    expq.push_back(16'h0100); expq.push_back(16'h0101);
    wreg(4'h6, 8'h03);
    repeat (5) tick();
    check("B_irq", 32'(irq), 0);
    check("B_queue", 32'(expq.size()), 0);
    check("B_snd", 32'(snd[7:0]), 32'(romv(16'h0101)));
    wreg(4'h6, 8'h00);
    check("B_keyoff_snd", 32'(snd[7:0]), 0);

    // Two channels served in priority order within one tick.
    prog(1'b1, 24'h000200, 24'h000205);
    expq.push_back(16'h0100); expq.push_back(16'h0200);
    wreg(4'h6, 8'h01);
    wreg(4'hE, 8'h01);
    tick();
    check("C_snd0", 32'(snd[7:0]), 32'(romv(16'h0100)));
    check("C_snd1", 32'(snd[15:8]), 32'(romv(16'h0200)));
    check("C_queue", 32'(expq.size()), 0);
    wreg(4'h6, 8'h00);
    wreg(4'hE, 8'h00);

    // Manual mode: cen ignored, one fetch per rising step.
    expq.push_back(16'h0200); expq.push_back(16'h0201);
    wreg(4'hE, 8'h05);
    f0 = fetches;
    tick();
    wreg(4'hF, 8'h01); wreg(4'hF, 8'h01); wreg(4'hF, 8'h01);
    wreg(4'hF, 8'h00);
    idle(8);
    wreg(4'hF, 8'h01);
    idle(12);
    check("D_fetches", 32'(fetches - f0), 2);
    check("D_queue", 32'(expq.size()), 0);
    check("D_snd1", 32'(snd[15:8]), 32'(romv(16'h0201)));
    wreg(4'hE, 8'h00);

    // Key-off while the fetch is waiting on the ROM.
    expq.push_back(16'h0100);
    wreg(4'h6, 8'h01);
    cen = 1'b1; @(negedge clk); cen = 1'b0;
    wait_cs(1'b1, "E_cs_rise");
    wreg(4'h6, 8'h00);
    wait_cs(1'b0, "E_cs_fall");
    idle(2);
    check("E_snd", 32'(snd[7:0]), 0);
    check("E_queue", 32'(expq.size()), 0);

    // Reset in the middle of a fetch.
    prog(1'b0, 24'h000100, 24'h000101);
    expq.push_back(16'h0100); expq.push_back(16'h0101);
    wreg(4'h6, 8'h01);
    tick();
    check("F_snd_pre", 32'(snd[7:0]), 32'(romv(16'h0100)));
    cen = 1'b1; @(negedge clk); cen = 1'b0;
    wait_cs(1'b1, "F_cs_rise");
    #2 rst = 1'b1;
    #1;
    check("F_rst_rom_cs", 32'(rom_cs), 0);
    check("F_rst_snd", 32'(snd), 0);
    check("F_rst_rom_addr", 32'(rom_addr), 0);
    check("F_rst_dout", 32'(dout), 0);
    check("F_rst_irq", 32'(irq), 0);
    @(negedge clk);
    idle(1);
    rst = 1'b0;
    idle(1);
    prog(1'b0, 24'h000100, 24'h000100);
    expq.push_back(16'h0100);
    wreg(4'h6, 8'h01);
    tick();
    check("F_snd_post", 32'(snd[7:0]), 32'(romv(16'h0100)));
    check("F_irq_post", 32'(irq), 1);
    check("F_queue", 32'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/jtvigil_pcmx.md
JTVIGIL_PCMX -- requirements
Module: jtvigil_pcmx

Interface
REQ-001 Parameter CH, default 2: number of PCM channels, legal 1..4.
REQ-002 Parameter AW, default 16: ROM sample address width, legal 9..24.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cen  in  1  sample-rate clock enable, one clk wide; each pulse starts one playback tick.
REQ-006 wr  in  1  CPU register write strobe, one clk per access.
REQ-007 rd  in  1  CPU status read strobe, one clk per access.
REQ-008 addr  in  $clog2(CH)+3  register select: upper bits = channel, low 3 bits = register.
REQ-009 din  in  8  CPU write data.
REQ-010 dout  out  8  status: bits[CH-1:0] busy, bits[CH+3:4] done flags.
REQ-011 rom_cs  out  1  ROM request.
REQ-012 rom_addr  out  AW  ROM byte address.
REQ-013 rom_data  in  8  ROM data.
REQ-014 rom_ok  in  1  ROM data valid for the current rom_addr.
REQ-015 snd  out  CH*8  per-channel unsigned 8-bit samples, channel 0 in bits 7:0.
REQ-016 irq  out  1  high while any done flag is set.

Function
REQ-017 Per-channel register map: 0/1/2 start address bytes lo/mid/hi; 3/4/5 end address bytes lo/mid/hi; 6 control; 7 step. Address bits at or above AW are ignored.
REQ-018 Control bits: bit0 key-on, bit1 loop, bit2 manual mode. A write with bit0=1 loads cur_addr<=start and sets busy. A write with bit0=0 clears busy immediately and forces that channel's snd to 0x00.
REQ-019 A start or end write during playback does not alter cur_addr; it takes effect at the next key-on or loop reload.
REQ-020 Auto mode (bit2=0): on each cen, every busy channel sets its pending bit. A pending bit that is already set stays set, so no fetch is duplicated.
REQ-021 Manual mode (bit2=1): cen is ignored. A step write sets pending only when the step strobe is high and was low on the previous clk (edge-detected).
REQ-022 Fetch FSM states: IDLE, ADDR, WAIT.
- IDLE: if any pending bit is set, select the lowest-index pending channel, drive rom_addr=cur_addr, go to ADDR.
- ADDR: raise rom_cs (rom_addr stable for 1 clk), go to WAIT.
- WAIT: keep rom_cs high; on the first clk with rom_ok=1, latch rom_data into that channel's snd, clear its pending bit, drop rom_cs, go to IDLE.
REQ-023 Minimum fetch latency is 3 clk from pending to snd update; an idle channel never drives rom_cs.
REQ-024 After each fetch, when cur_addr != end: cur_addr increments by 1, wrapping at 2^AW to 0.
REQ-025 After each fetch, when cur_addr == end: with loop=1, cur_addr<=start; with loop=0, busy clears, the done flag sets, and snd holds the last sample.
REQ-026 A key-on write in the same clk as end-of-sample: key-on wins (busy stays 1, cur_addr<=start, done still sets).
REQ-027 Key-off of the channel currently in WAIT: the fetch completes on the ROM side, but data is discarded and snd stays 0x00.
REQ-028 A read (rd=1) returns status on dout in the same clk (combinational) and clears the done flags that were set before that clk; a flag setting in the same clk survives.
REQ-029 dout is 0x00 when rd=0.
REQ-030 Writes to channels >= CH are ignored.

Reset
REQ-031 Reset sets all of these to zero: registers, cur_addr, pending, busy, done, snd, rom_cs, rom_addr, irq. FSM goes to IDLE.
REQ-032 Reset asserted mid-fetch drops rom_cs in the same clk, with no snd update.

Verification
REQ-033 CH=2. Ch0 start=0x0100, end=0x0102, key-on, 4 cen pulses, rom_ok after 2 clk -> snd[7:0]=ROM[0x100],[0x101],[0x102]; then busy0=0, irq=1; the 4th cen gives no rom_cs.
REQ-034 Same setup with loop=1, 5 cen pulses -> rom_addr sequence 0x100,0x101,0x102,0x100,0x101; irq stays 0.
REQ-035 Both channels keyed on, one cen pulse -> ch0 fetched first, then ch1 (rom_cs never overlaps); both snd lanes update within one tick.
REQ-036 Ch1 manual mode, step held high for 3 clk, then low, then high again -> exactly 2 fetches.
REQ-037 Status read with done0 set -> dout bit4=1 and irq drops the next clk. Key-off during WAIT -> snd lane reads 0x00 after rom_ok.
REQ-038 rst pulse during WAIT -> rom_cs=0 and all outputs 0 while rst is high; normal operation resumes after a fresh key-on.
